// File: rtl/rvee_csr_exec.sv
// rvee_csr_exec: Zicsr sequencer that drives the CSR-file port and returns the old value or a trap.
// Optional build macro RVEE_CSR_SERIALIZE_EN holds each access until older instructions retire.
module rvee_csr_exec #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic [11:0]     req_csr,
    input  logic [4:0]      req_rs1,
    input  logic [XLEN-1:0] req_rs1_val,
    input  logic [4:0]      req_rd,
    input  logic [XLEN-1:0] req_pc,
    output logic [11:0]     csr_reg,
    output logic [1:0]      csr_op,
    output logic [XLEN-1:0] csr_wdata,
    output logic            csr_r_en,
    output logic            csr_w_en,
    output logic [XLEN-1:0] csr_pc,
    input  logic [XLEN-1:0] csr_rdata,
    input  logic            csr_illegal,
    input  logic            pipe_empty,
    output logic            rd_we,
    output logic [4:0]      rd_idx,
    output logic [XLEN-1:0] rd_data,
    output logic            exc_valid,
    output logic [3:0]      exc_cause,
    output logic [XLEN-1:0] exc_tval
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next_state;

    logic [2:0]        r_funct3;
    logic [11:0]       r_csr;
    logic [4:0]        r_rs1;
    logic [XLEN-1:0]   r_rs1_val;
    logic [4:0]        r_rd;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_rdata;
    logic              r_illegal;

    logic              w_accept;
    logic [1:0]        w_op;
    logic              w_imm;
    logic              w_op_none;
    logic              w_rd_nz;
    logic              w_rs1_nz;
    logic              w_r_cond;
    logic              w_w_cond;
    logic [31:0]       w_insn;

`ifndef RVEE_CSR_SERIALIZE_EN
    logic              w_unused_pipe_empty;
    assign w_unused_pipe_empty = pipe_empty;
`endif

    assign w_accept  = req_valid && (r_state == S_IDLE);
    assign w_op      = r_funct3[1:0];
    assign w_imm     = r_funct3[2];
    assign w_op_none = (w_op == 2'b00);
    assign w_rd_nz   = (r_rd != 5'd0);
    assign w_rs1_nz  = (r_rs1 != 5'd0);
    // Reserved op (funct3 x00) never touches the CSR file; it only produces a trap.
    assign w_r_cond  = !w_op_none && ((w_op != 2'b01) || w_rd_nz);
    assign w_w_cond  = !w_op_none && ((w_op == 2'b01) || w_rs1_nz);
    assign w_insn    = {r_csr, r_rs1, r_funct3, r_rd, 7'b1110011};

    assign csr_reg   = r_csr;
    assign csr_op    = w_op;
    assign csr_wdata = w_imm ? XLEN'(r_rs1) : r_rs1_val;
    assign csr_pc    = r_pc;
    assign rd_idx    = r_rd;
    assign rd_data   = r_rdata;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Latch the accepted request; fields hold until the next accept
    always_ff @(posedge clk) begin
        if (rst) begin
            r_funct3  <= 3'd0;
            r_csr     <= 12'd0;
            r_rs1     <= 5'd0;
            r_rs1_val <= '0;
            r_rd      <= 5'd0;
            r_pc      <= '0;
        end else if (w_accept) begin
            r_funct3  <= req_funct3;
            r_csr     <= req_csr;
            r_rs1     <= req_rs1;
            r_rs1_val <= req_rs1_val;
            r_rd      <= req_rd;
            r_pc      <= req_pc;
        end
    end

    // Capture the CSR file's answer at the end of the access cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata   <= '0;
            r_illegal <= 1'b0;
        end else if (r_state == S_ACCESS) begin
            r_rdata   <= csr_rdata;
            r_illegal <= w_op_none || csr_illegal;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
`ifdef RVEE_CSR_SERIALIZE_EN
                    w_next_state = S_WAIT;
`else
                    w_next_state = S_ACCESS;
`endif
                end else begin
                    w_next_state = S_IDLE;
                end
            end
`ifdef RVEE_CSR_SERIALIZE_EN
            S_WAIT: begin
                if (pipe_empty) begin
                    w_next_state = S_ACCESS;
                end else begin
                    w_next_state = S_WAIT;
                end
            end
`endif
            S_ACCESS: w_next_state = S_RESP;
            S_RESP:   w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Output decode from the state register
    always_comb begin
        req_ready = 1'b0;
        csr_r_en  = 1'b0;
        csr_w_en  = 1'b0;
        rd_we     = 1'b0;
        exc_valid = 1'b0;
        exc_cause = 4'd0;
        exc_tval  = '0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
            end
            S_ACCESS: begin
                csr_r_en = w_r_cond;
                csr_w_en = w_w_cond;
            end
            S_RESP: begin
                if (r_illegal) begin
                    exc_valid = 1'b1;
                    exc_cause = 4'd2;
                    exc_tval  = XLEN'(w_insn);
                end else begin
                    rd_we = w_rd_nz;
                end
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

endmodule
